// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: command opcodes,
// interrupt/reset vector addresses and the FSM state type.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    OP_INC    = 2'd0,
    OP_ABS    = 2'd1,
    OP_BRANCH = 2'd2,
    OP_VEC    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    RST_LO,
    RST_HI,
    IDLE,
    ABS_HI,
    BR_FIX,
    VEC_LO,
    VEC_HI
  } state_e;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  // Selects 2 and 3 both alias the top vector.
  function automatic logic [15:0] vec_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    return VEC_NMI;
      2'd1:    return VEC_RST;
      default: return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/pc_byte.sv
// One byte of the program counter: a loadable register plus an adder whose
// result and carry-out feed back through the sequencer's load mux.
module pc_byte (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] d,
  input  logic [7:0] addend,
  input  logic       cin,
  output logic [7:0] q,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] total;

  assign total = {1'b0, q} + {1'b0, addend} + {8'd0, cin};
  assign sum   = total[7:0];
  assign cout  = total[8];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= 8'h00;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: INC / ABS / BRANCH / VEC commands, with a
// two-beat reset-vector fetch and a fix-up cycle for page-crossing branches.
module pc_seq
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic [15:0] pc,
  output logic        done,
  output logic        page_cross,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data
);

  state_e     state, state_nxt;
  logic [7:0] lat, lat_nxt;
  logic       br_dec, br_dec_nxt;
  logic [1:0] vsel, vsel_nxt;
  logic       done_nxt, cross_nxt;

  logic       lo_load, lo_cin, lo_cout;
  logic [7:0] lo_d, lo_add, lo_q, lo_sum;
  logic       hi_load, hi_cin;
  logic [7:0] hi_d, hi_add, hi_q, hi_sum;

  logic       accept;
  logic       br_cross;

  pc_byte u_lo (
    .clk(clk), .rst_n(rst_n), .load(lo_load), .d(lo_d),
    .addend(lo_add), .cin(lo_cin), .q(lo_q), .sum(lo_sum), .cout(lo_cout)
  );

  pc_byte u_hi (
    .clk(clk), .rst_n(rst_n), .load(hi_load), .d(hi_d),
    .addend(hi_add), .cin(hi_cin), .q(hi_q), .sum(hi_sum), .cout()
  );

  assign pc     = {hi_q, lo_q};
  assign accept = cmd_valid && cmd_ready;
  // Negative offsets sign-extend to FF in the high byte, so no carry there
  // means a borrow; positive offsets cross only on carry.
  assign br_cross = cmd_data[7] ? !lo_cout : lo_cout;

  // NOTE: every signal written here gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    lat_nxt    = lat;
    br_dec_nxt = br_dec;
    vsel_nxt   = vsel;
    done_nxt   = 1'b0;
    cross_nxt  = 1'b0;
    cmd_ready  = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = 16'h0000;
    lo_load    = 1'b0;
    lo_d       = lo_sum;
    lo_add     = 8'h00;
    lo_cin     = 1'b0;
    hi_load    = 1'b0;
    hi_d       = hi_sum;
    hi_add     = 8'h00;
    hi_cin     = 1'b0;

    case (state)
      RST_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = VEC_RST;
        lat_nxt   = mem_data;
        state_nxt = RST_HI;
      end
      RST_HI: begin
        mem_rd    = 1'b1;
        mem_addr  = VEC_RST + 16'd1;
        lo_load   = 1'b1;
        lo_d      = lat;
        hi_load   = 1'b1;
        hi_d      = mem_data;
        state_nxt = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          case (op_e'(cmd_op))
            OP_INC: begin
              lo_cin   = 1'b1;
              lo_load  = 1'b1;
              hi_cin   = lo_cout;
              hi_load  = 1'b1;
              done_nxt = 1'b1;
            end
            OP_ABS: begin
              lat_nxt   = cmd_data;
              state_nxt = ABS_HI;
            end
            OP_BRANCH: begin
              lo_add  = cmd_data;
              lo_load = 1'b1;
              if (br_cross) begin
                br_dec_nxt = cmd_data[7];
                state_nxt  = BR_FIX;
              end else begin
                done_nxt = 1'b1;
              end
            end
            default: begin
              vsel_nxt  = cmd_data[1:0];
              state_nxt = VEC_LO;
            end
          endcase
        end
      end
      ABS_HI: begin
        cmd_ready = 1'b1;
        if (accept) begin
          lo_load   = 1'b1;
          lo_d      = lat;
          hi_load   = 1'b1;
          hi_d      = cmd_data;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      BR_FIX: begin
        hi_add    = br_dec ? 8'hFF : 8'h00;
        hi_cin    = !br_dec;
        hi_load   = 1'b1;
        done_nxt  = 1'b1;
        cross_nxt = 1'b1;
        state_nxt = IDLE;
      end
      VEC_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = vec_addr(vsel);
        lat_nxt   = mem_data;
        state_nxt = VEC_HI;
      end
      VEC_HI: begin
        mem_rd    = 1'b1;
        mem_addr  = vec_addr(vsel) + 16'd1;
        lo_load   = 1'b1;
        lo_d      = lat;
        hi_load   = 1'b1;
        hi_d      = mem_data;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = RST_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_LO;
      lat        <= 8'h00;
      br_dec     <= 1'b0;
      vsel       <= 2'd0;
      done       <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat        <= lat_nxt;
      br_dec     <= br_dec_nxt;
      vsel       <= vsel_nxt;
      done       <= done_nxt;
      page_cross <= cross_nxt;
    end
  end

endmodule
